// File: rtl/cla_add_sequencer_pkg.sv
// cla_seq_pkg: shared FSM encoding, slice width and operand-width check for the CLA add sequencer.
package cla_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  function automatic bit width_ok(input int w);
    return (w % NIBBLE_W == 0) && (w >= 2 * NIBBLE_W);
  endfunction
endpackage

// File: rtl/cla_add_sequencer_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p, c;
  assign g = a & b;
  assign p = a | b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s = a ^ b ^ c;
endmodule

// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer: multi-precision adder sequencing one nibble per cycle through a shared 4-bit CLA slice.
// Define CLA_SEQ_SUBTRACT_EN to add the i_sub port for A-B.
module cla_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
`ifdef CLA_SEQ_SUBTRACT_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_s,
  output logic             o_busy
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW = $clog2(NIBBLES);
  if (!width_ok(WIDTH)) begin : g_width_err
    $error("cla_add_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, last, co;
  logic [NIBBLE_W-1:0] sum;
  logic [WIDTH-1:0] b_in;
  logic c_in;
`ifdef CLA_SEQ_SUBTRACT_EN
  assign b_in = i_sub ? ~i_b : i_b;
  assign c_in = i_sub ? 1'b1 : i_c;
`else
  assign b_in = i_b;
  assign c_in = i_c;
`endif
  assign last = idx == IW'(NIBBLES - 1);
  cla4_slice u_slice (
    .a (a_r[idx*NIBBLE_W +: NIBBLE_W]),
    .b (b_r[idx*NIBBLE_W +: NIBBLE_W]),
    .ci(carry),
    .s (sum),
    .co(co)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = i_valid ? RUN : IDLE;
    else if (state == RUN) state_n = last ? DONE : RUN;
    else state_n = i_ready ? IDLE : DONE;
    o_ready = state == IDLE;
    o_valid = state == DONE;
    o_busy  = state != IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      o_s   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && i_valid) begin
        a_r   <= i_a;
        b_r   <= b_in;
        carry <= c_in;
        idx   <= '0;
        o_s   <= '0;
      end else if (state == RUN) begin
        o_s[idx*NIBBLE_W +: NIBBLE_W] <= sum;
        carry <= co;
        idx   <= idx + IW'(1);
        if (last) o_s[WIDTH] <= co;
      end
    end
  end
endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb_cla_add_sequencer: randomized self-checking bench against an arithmetic reference model.
module tb_cla_add_sequencer;
  localparam int W = 16;
  logic i_clk = 0, i_rst = 1, i_valid = 0, i_ready = 1, i_c = 0, i_sub = 0;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic o_ready, o_valid, o_busy;
  logic [W:0] o_s;
  int total = 0, bad = 0;

  cla_add_sequencer #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_c(i_c),
`ifdef CLA_SEQ_SUBTRACT_EN
    .i_sub(i_sub),
`endif
    .o_valid(o_valid), .i_ready(i_ready), .o_s(o_s), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c, s);
    logic [W-1:0] nb;
    nb = ~b;
    return s ? (W+1)'(a) + (W+1)'(nb) + (W+1)'(1) : (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
  endfunction

  // Issues one request at a negedge in IDLE and checks latency, result, stall hold and release.
  task automatic run_op(input logic [W-1:0] a, b, input logic c, s, input int stall, input bit mutate);
    logic [W:0] exp;
    int n;
    exp = model(a, b, c, s);
    @(negedge i_clk);
    i_a = a; i_b = b; i_c = c; i_sub = s; i_valid = 1; i_ready = (stall == 0);
    chk("ready_idle", o_ready, 1);
    @(posedge i_clk);
    n = 1;
    @(negedge i_clk);
    i_valid = 0;
    if (mutate) begin i_a = W'($urandom); i_b = W'($urandom); i_c = ~c; i_sub = ~s; end
    while (!o_valid && n < 20) begin
      @(posedge i_clk); n++;
      @(negedge i_clk);
    end
    chk("latency", n, 5);
    chk("sum", o_s, exp);
    chk("busy_done", o_busy, 1);
    for (int k = 0; k < stall; k++) begin
      i_valid = 1; i_a = W'($urandom); i_b = W'($urandom);
      chk("stall_ready", o_ready, 0);
      @(posedge i_clk);
      @(negedge i_clk);
      chk("stall_valid", o_valid, 1);
      chk("stall_hold", o_s, exp);
    end
    i_valid = 0; i_ready = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("valid_drop", o_valid, 0);
    chk("ready_back", o_ready, 1);
  endtask

  initial begin
    int acc, nv, seen;
    logic [W-1:0] ra, rb;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_s", o_s, 0);
    chk("rst_busy", o_busy, 0);
    i_rst = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1);

    run_op(16'hFFFF, 16'h0001, 0, 0, 0, 0);
    run_op(16'h1234, 16'h4321, 1, 0, 0, 1);
    run_op(16'h8000, 16'h8000, 0, 0, 3, 0);

    // reset on the second RUN cycle must discard the operation
    @(negedge i_clk);
    i_a = 16'h00FF; i_b = 16'h0F0F; i_valid = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_s", o_s, 0);
    seen = 0;
    repeat (8) begin
      if (o_valid) seen++;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    chk("midrst_novalid", seen, 0);
    run_op(16'h0001, 16'h0002, 0, 0, 0, 0);

    // back-to-back: i_valid held high for two operation periods
    @(negedge i_clk);
    ra = W'($urandom); rb = W'($urandom);
    i_a = ra; i_b = rb; i_c = 1; i_sub = 0; i_valid = 1; i_ready = 1;
    acc = 0; nv = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_ready && i_valid) acc++;
      if (o_valid) begin nv++; chk("b2b_sum", o_s, model(ra, rb, 1, 0)); end
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_valid = 0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_valids", nv, 2);
    chk("b2b_idle", o_ready, 1);

`ifdef CLA_SEQ_SUBTRACT_EN
    run_op(16'h0005, 16'h0007, 0, 1, 0, 0);
    run_op(16'h0007, 16'h0005, 0, 1, 1, 0);
`endif

    for (int k = 0; k < 20; k++) begin
`ifdef CLA_SEQ_SUBTRACT_EN
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
`else
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, int'($urandom_range(0, 2)), 1'($urandom));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
